// File: rtl/bcd_convert_if.sv
// Handshake bundle between the binary producer, the BCD converter and the display consumer.
interface bcd_convert_if #(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      in_bin;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_bcd;
  logic                  out_ovf;

  modport slave (
    input  in_valid, in_bin, out_ready,
    output in_ready, out_valid, out_bcd, out_ovf
  );

  modport master (
    output in_valid, in_bin, out_ready,
    input  in_ready, out_valid, out_bcd, out_ovf
  );
endinterface

// File: rtl/bcd_convert_ctrl.sv
// Iterative double-dabble binary-to-BCD converter, one operand per handshake.
// Optional macro BCD_SATURATE_EN: overflowing results are reported as all nines.
module bcd_convert_ctrl #(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  bcd_convert_if.slave  bus
);

  localparam int BCD_W  = 4 * (DIGITS + 1);
  localparam int OUT_W  = 4 * DIGITS;
  localparam int ITER_W = $clog2(BIN_W);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(BIN_W - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]              state;
  logic [ITER_W-1:0]       iter;
  logic [BIN_W-1:0]        bin_sr;
  logic [BCD_W-1:0]        bcd_sr;
  logic [OUT_W-1:0]        out_bcd_r;
  logic                    out_ovf_r;

  logic [BCD_W-1:0]        bcd_adj;
  logic [BCD_W+BIN_W-1:0]  shifted;
  logic [BCD_W-1:0]        bcd_next;
  logic [BIN_W-1:0]        bin_next;
  logic [OUT_W-1:0]        low_next;
  logic                    ovf_next;

  // Each digit is at most 9 before correction, so the 4-bit add cannot carry out.
  function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (b[4*i +: 4] >= 4'd5)
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [OUT_W-1:0] saturate(input logic [OUT_W-1:0] low,
                                                input logic             ovf);
    return ovf ? {DIGITS{4'h9}} : low;
  endfunction

  always_comb begin
    bcd_adj  = add3_digits(bcd_sr);
    shifted  = {bcd_adj, bin_sr} << 1;
    bcd_next = shifted[BCD_W+BIN_W-1:BIN_W];
    bin_next = shifted[BIN_W-1:0];
    low_next = bcd_next[OUT_W-1:0];
    ovf_next = |bcd_next[BCD_W-1 -: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      iter      <= '0;
      bin_sr    <= '0;
      bcd_sr    <= '0;
      out_bcd_r <= '0;
      out_ovf_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            bin_sr <= bus.in_bin;
            bcd_sr <= '0;
            iter   <= '0;
            state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          bin_sr <= bin_next;
          bcd_sr <= bcd_next;
          iter   <= iter + 1'b1;
          if (iter == LAST_ITER) begin
            state     <= S_DONE;
            out_ovf_r <= ovf_next;
`ifdef BCD_SATURATE_EN
            out_bcd_r <= saturate(low_next, ovf_next);
`else
            out_bcd_r <= low_next;
`endif
          end
        end
        S_DONE: begin
          if (bus.out_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.out_bcd   = out_bcd_r;
  assign bus.out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_bcd_convert_ctrl.sv
// Self-checking bench for bcd_convert_ctrl: vector table, corner sequences and random operands.
module tb_bcd_convert_ctrl;

  localparam int BIN_W  = 20;
  localparam int DIGITS = 6;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   cyc;

  bcd_convert_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  bcd_convert_ctrl #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [19:0] bin;
    logic [23:0] bcd;
    logic        ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain decimal arithmetic on the operand value.
  function automatic void model(input int unsigned v, output logic [23:0] bcd, output logic ovf);
    int unsigned low;
    ovf = (v > 999999);
    low = v % 1000000;
    bcd = '0;
    for (int i = 0; i < 6; i++) begin
      bcd[4*i +: 4] = 4'(low % 10);
      low = low / 10;
    end
`ifdef BCD_SATURATE_EN
    if (ovf) bcd = 24'h999999;
`endif
  endfunction

  // Called #1 after a rising edge. Returns the result and the cycle stamp of the accept edge.
  task automatic run_conv(input logic [19:0] v, input int hold, input bit mess,
                          output logic [23:0] bcd, output logic ovf, output int acc);
    int  n;
    int  lat;
    bit  ok;
    bus.in_valid = 1'b1;
    bus.in_bin   = v;
    n = 0;
    while (!bus.in_ready && n < 60) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_wait", 32'(n < 60), 32'd1);
    @(posedge clk); #1;
    acc = cyc;
    bus.in_valid = mess ? 1'($urandom) : 1'b0;
    bus.in_bin   = mess ? 20'($urandom) : 20'd0;
    ok  = 1'b1;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) ok = 1'b0;
      @(posedge clk); #1; lat++;
      if (mess) begin
        bus.in_valid = 1'($urandom);
        bus.in_bin   = 20'($urandom);
      end
    end
    chk("latency", 32'(lat), 32'd20);
    chk("shift_ready_low", 32'(ok), 32'd1);
    bcd = bus.out_bcd;
    ovf = bus.out_ovf;
    ok  = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!bus.out_valid || bus.in_ready || bus.out_bcd !== bcd || bus.out_ovf !== ovf) ok = 1'b0;
      if (mess) begin
        bus.in_valid = 1'($urandom);
        bus.in_bin   = 20'($urandom);
      end
    end
    if (hold > 0) chk("hold_stable", 32'(ok), 32'd1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("release_valid_low", {30'd0, bus.out_valid, bus.in_ready}, 32'b01);
    chk("release_retain", {7'd0, bus.out_ovf, bus.out_bcd}, {7'd0, ovf, bcd});
  endtask

  vec_t        tbl[6];
  logic [23:0] got_bcd, exp_bcd;
  logic        got_ovf, exp_ovf;
  int          a0, a1;

  initial begin
    tests = 0;
    fails = 0;
    cyc   = 0;
    bus.in_valid  = 1'b0;
    bus.in_bin    = '0;
    bus.out_ready = 1'b0;

    tbl[0] = '{bin: 20'd123456,  bcd: 24'h123456, ovf: 1'b0};
    tbl[1] = '{bin: 20'd0,       bcd: 24'h000000, ovf: 1'b0};
    tbl[2] = '{bin: 20'd999999,  bcd: 24'h999999, ovf: 1'b0};
`ifdef BCD_SATURATE_EN
    tbl[3] = '{bin: 20'd1048575, bcd: 24'h999999, ovf: 1'b1};
    tbl[4] = '{bin: 20'd1000000, bcd: 24'h999999, ovf: 1'b1};
`else
    tbl[3] = '{bin: 20'd1048575, bcd: 24'h048575, ovf: 1'b1};
    tbl[4] = '{bin: 20'd1000000, bcd: 24'h000000, ovf: 1'b1};
`endif
    tbl[5] = '{bin: 20'd654321,  bcd: 24'h654321, ovf: 1'b0};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_state", {6'd0, bus.in_ready, bus.out_valid, bus.out_ovf, bus.out_bcd},
        {6'd0, 1'b1, 1'b0, 1'b0, 24'h000000});

    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      run_conv(tbl[i].bin, 0, 1'b0, got_bcd, got_ovf, a0);
      chk($sformatf("tbl%0d_bcd", i), 32'(got_bcd), 32'(tbl[i].bcd));
      chk($sformatf("tbl%0d_ovf", i), 32'(got_ovf), 32'(tbl[i].ovf));
    end

    // Back-to-back accepts with the consumer always ready.
    run_conv(20'd0, 0, 1'b0, got_bcd, got_ovf, a0);
    chk("b2b0_bcd", 32'(got_bcd), 32'h000000);
    run_conv(20'd999999, 0, 1'b0, got_bcd, got_ovf, a1);
    chk("b2b1_bcd", 32'(got_bcd), 32'h999999);
    chk("b2b_spacing", 32'(a1 - a0), 32'd22);

    // Backpressure with noisy inputs while busy.
    run_conv(20'd777123, 5, 1'b1, got_bcd, got_ovf, a0);
    chk("bp_bcd", {7'd0, got_ovf, got_bcd}, {7'd0, 1'b0, 24'h777123});

    // Reset after 10 shift iterations; previous result is nonzero so clearing is visible.
    bus.in_valid = 1'b1;
    bus.in_bin   = 20'd314159;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {6'd0, bus.in_ready, bus.out_valid, bus.out_ovf, bus.out_bcd},
        {6'd0, 1'b1, 1'b0, 1'b0, 24'h000000});
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_idle", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
    run_conv(20'd654321, 0, 1'b0, got_bcd, got_ovf, a0);
    chk("post_reset_conv", {7'd0, got_ovf, got_bcd}, {7'd0, 1'b0, 24'h654321});

    // Random operands over the full input range, including overflow values.
    for (int i = 0; i < 30; i++) begin
      logic [19:0] v;
      v = 20'($urandom);
      if (i % 5 == 0) v = 20'($urandom_range(999990, 1000010));
      model(int'(v), exp_bcd, exp_ovf);
      run_conv(v, $urandom_range(0, 3), 1'($urandom), got_bcd, got_ovf, a0);
      chk($sformatf("rand_%0d_v%0d", i, v), {7'd0, got_ovf, got_bcd}, {7'd0, exp_ovf, exp_bcd});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
